// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the single R/W port of dumbMem.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin ties (default: fixed priority to requester 0).
module mem_port_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_select,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_owner;
   logic                r_last_grant;
   logic [ADDR_W-1:0]   r_lat_addr;
   logic                r_lat_we;
   logic [DATA_W-1:0]   r_lat_wdata;
   logic [DATA_W-1:0]   r_rdata0;
   logic [DATA_W-1:0]   r_rdata1;

   logic                w_any;
   logic                w_win;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic                w_sel_we;
   logic [DATA_W-1:0]   w_sel_wdata;

   assign w_any = req0 | req1;

   // Winner selection: a lone request always wins; only ties consult the policy.
   always_comb begin
      w_win = 1'b0;
      if (req0 && req1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         w_win = ~r_last_grant;
`else
         w_win = 1'b0;
`endif
      end else if (req1) begin
         w_win = 1'b1;
      end
      w_sel_addr  = w_win ? addr1  : addr0;
      w_sel_we    = w_win ? we1    : we0;
      w_sel_wdata = w_win ? wdata1 : wdata0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_lat_addr   <= '0;
         r_lat_we     <= 1'b0;
         r_lat_wdata  <= '0;
         r_rdata0     <= '0;
         r_rdata1     <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_any) begin
            r_owner      <= w_win;
            r_last_grant <= w_win;
            r_lat_addr   <= w_sel_addr;
            r_lat_we     <= w_sel_we;
            r_lat_wdata  <= w_sel_wdata;
         end
         if (r_state == S_ACCESS && !r_lat_we) begin
            if (r_owner)
               r_rdata1 <= mem_rdata;
            else
               r_rdata0 <= mem_rdata;
         end
      end
   end

   // Memory strobes are gated by reset so an aborted ACCESS cycle never commits.
   always_comb begin
      w_next     = r_state;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      ack0       = 1'b0;
      ack1       = 1'b0;
      mem_select = '0;
      mem_wdata  = '0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) w_next = S_ACCESS;
         end
         S_ACCESS: begin
            gnt0       = ~r_owner;
            gnt1       = r_owner;
            mem_select = r_lat_addr;
            mem_wdata  = r_lat_wdata;
            mem_write  = r_lat_we & ~reset;
            mem_read   = ~r_lat_we & ~reset;
            w_next     = S_RESP;
         end
         S_RESP: begin
            gnt0   = ~r_owner;
            gnt1   = r_owner;
            ack0   = ~r_owner;
            ack1   = r_owner;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign rdata0 = r_rdata0;
   assign rdata1 = r_rdata1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter with a 1024x32 memory model.
module tb_mem_port_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [9:0]  addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, ack0, ack1;
   logic [31:0] rdata0, rdata1;
   logic [9:0]  mem_select;
   logic [31:0] mem_wdata;
   logic        mem_write, mem_read;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:1023];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clock = ~clock;

   mem_port_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_select(mem_select), .mem_wdata(mem_wdata),
      .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
   );

   assign mem_rdata = mem[mem_select];
   always @(posedge clock) if (mem_write) mem[mem_select] <= mem_wdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   int ack_seq[$];
   int ack1_cnt;

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      reset = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      step(); step();
      check("rst_gnt0", 32'(gnt0), 0);
      check("rst_gnt1", 32'(gnt1), 0);
      check("rst_ack", 32'({ack0, ack1}), 0);
      check("rst_mem_strobes", 32'({mem_write, mem_read}), 0);
      check("rst_mem_select", 32'(mem_select), 0);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      reset = 1'b0;
      step();

      // requester 0 write 512 <= 1
      req0 = 1; we0 = 1; addr0 = 10'd512; wdata0 = 32'h1;
      step();
      check("w0_mem_write", 32'(mem_write), 1);
      check("w0_mem_read", 32'(mem_read), 0);
      check("w0_mem_select", 32'(mem_select), 512);
      check("w0_mem_wdata", mem_wdata, 32'h1);
      check("w0_gnt0", 32'(gnt0), 1);
      check("w0_ack0_early", 32'(ack0), 0);
      step();
      check("w0_ack0", 32'(ack0), 1);
      check("w0_ack1", 32'(ack1), 0);
      check("w0_resp_strobe", 32'(mem_write), 0);
      req0 = 0;
      step();
      check("w0_ack0_drop", 32'(ack0), 0);
      check("w0_mem512", mem[512], 32'h1);

      // requester 0 read back 512
      req0 = 1; we0 = 0; addr0 = 10'd512;
      step();
      check("r0_mem_read", 32'(mem_read), 1);
      check("r0_mem_write", 32'(mem_write), 0);
      step();
      check("r0_ack0", 32'(ack0), 1);
      check("r0_rdata0", rdata0, 32'h1);
      req0 = 0;
      step();

      // requester 1 write 5 <= DEADBEEF
      req1 = 1; we1 = 1; addr1 = 10'd5; wdata1 = 32'hDEADBEEF;
      step();
      check("w1_mem_select", 32'(mem_select), 5);
      check("w1_gnt", 32'({gnt0, gnt1}), 32'b01);
      step();
      check("w1_acks", 32'({ack0, ack1}), 32'b01);
      check("w1_rdata0_held", rdata0, 32'h1);
      req1 = 0;
      step();
      req0 = 1; we0 = 0; addr0 = 10'd5;
      step(); step();
      check("r5_ack0", 32'(ack0), 1);
      check("r5_rdata0", rdata0, 32'hDEADBEEF);
      req0 = 0;
      step();

      // continuous contention from a fresh reset
      reset = 1; step(); reset = 0;
      req0 = 1; we0 = 0; addr0 = 10'd512;
      req1 = 1; we1 = 0; addr1 = 10'd5;
      ack1_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         check("both_acks_never", 32'(ack0 & ack1), 0);
         if (ack0) ack_seq.push_back(0);
         if (ack1) begin ack_seq.push_back(1); ack1_cnt++; end
      end
      req0 = 0; req1 = 0;
      check("cont_ack_count", 32'(ack_seq.size()), 4);
      for (int i = 0; i < 4; i++) begin
         int got_w;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         int exp_w = i % 2;
`else
         int exp_w = 0;
`endif
         got_w = (i < ack_seq.size()) ? ack_seq[i] : -1;
         check($sformatf("cont_order_%0d", i), 32'(got_w), 32'(exp_w));
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      check("cont_ack1_count", 32'(ack1_cnt), 2);
`else
      check("cont_ack1_starved", 32'(ack1_cnt), 0);
`endif
      step();

      // reset during ACCESS of a write to addr 7
      req0 = 1; we0 = 1; addr0 = 10'd7; wdata0 = 32'h12345678;
      step();
      check("rstmid_access_write", 32'(mem_write), 1);
      reset = 1; req0 = 0;
      #1;
      check("rstmid_write_gated", 32'(mem_write), 0);
      step();
      check("rstmid_no_ack", 32'({ack0, ack1}), 0);
      check("rstmid_no_gnt", 32'({gnt0, gnt1}), 0);
      reset = 0;
      step();
      check("rstmid_no_ack_after", 32'({ack0, ack1}), 0);
      check("rstmid_mem7", mem[7], 32'h0);
      req0 = 1; we0 = 0; addr0 = 10'd7;
      step(); step();
      check("rstmid_read7_ack", 32'(ack0), 1);
      check("rstmid_read7", rdata0, 32'h0);
      req0 = 0;
      step();

      // requester changes addr/wdata while the access is in flight
      req0 = 1; we0 = 1; addr0 = 10'd100; wdata0 = 32'hA5A5A5A5;
      step();
      addr0 = 10'd200; wdata0 = 32'hFFFFFFFF;
      #1;
      check("chg_mem_select", 32'(mem_select), 100);
      check("chg_mem_wdata", mem_wdata, 32'hA5A5A5A5);
      step();
      check("chg_ack0", 32'(ack0), 1);
      req0 = 0;
      step();
      check("chg_mem100", mem[100], 32'hA5A5A5A5);
      check("chg_mem200", mem[200], 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single read/write data port of the 1024×32 `dumbMem` memory between two requesters:
- requester 0: the CPU load/store path (`memSelect1` / `regToMem` / `memWrite1_out`);
- requester 1: a program loader/debug master.

It captures one request at a time, drives the memory port for exactly one cycle, and returns an ack (plus read data for loads) to the winner. It sits between `cpu`/loader and `dumbMem` port 1; the instruction-fetch port 2 is untouched.

## Interface
- `ADDR_W`, 10, memory word-address width
- `DATA_W`, 32, data width

- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `req0`, `req1`  in  1  access request; held high until matching ack
- `we0`, `we1`  in  1  1 = write, 0 = read; valid while req high
- `addr0`, `addr1`  in  ADDR_W  word address
- `wdata0`, `wdata1`  in  DATA_W  write data
- `gnt0`, `gnt1`  out  1  requester owns port (ACCESS and RESP states)
- `ack0`, `ack1`  out  1  one-cycle completion pulse
- `rdata0`, `rdata1`  out  DATA_W  registered read data, held until next read by same requester
- `mem_select`  out  ADDR_W  to memory select1
- `mem_wdata`  out  DATA_W  to memory inputVal1
- `mem_write`  out  1  to memory write1
- `mem_read`  out  1  to memory read1
- `mem_rdata`  in  DATA_W  from memory outVal1 (combinational read of `mem_select`)

## Operation
- FSM states: IDLE, ACCESS, RESP. Registers: `state`, `owner` (1 bit), `last_grant` (1 bit), latched `lat_addr`/`lat_we`/`lat_wdata`.
- IDLE: if any req high, choose a winner, latch its addr/we/wdata, set `owner`, update `last_grant`, go to ACCESS. With no req, stay in IDLE.
- ACCESS:
  - `mem_select` = `lat_addr`, `mem_wdata` = `lat_wdata`.
  - `mem_write` = `lat_we`; `mem_read` = !`lat_we`.
  - On the closing edge of a read, `rdata[owner]` <= `mem_rdata`.
  - Next state RESP.
- RESP: `ack[owner]` = 1 and `gnt[owner]` = 1; next state IDLE unconditionally.
- Requester contract:
  - Drop req in the cycle after ack (the IDLE cycle).
  - A req still high in IDLE is treated as a new request.
  - Changing addr/we/wdata after the IDLE capture edge has no effect on the current access.
- Arbitration (see Configuration): single request wins outright. Tie is resolved by policy.
- Outside ACCESS: `mem_select`, `mem_wdata`, `mem_write` and `mem_read` are all 0.
- Reset mid-operation:
  - Next edge forces IDLE.
  - `mem_write` and `mem_read` are gated to 0 combinationally while reset is high, so an ACCESS cycle coincident with reset writes nothing.
  - No ack is issued for the aborted access.

## Timing
- Reset values:
  - `state` = IDLE, `last_grant` = 1, `owner` = 0.
  - All `gnt`, `ack`, `mem_*` outputs = 0.
  - `rdata0` = `rdata1` = 0.
- Latency, with req sampled high in IDLE at cycle T:
  - T+1 = ACCESS (memory driven, write commits at the end of T+1).
  - T+2 = RESP (ack high, rdata valid).
  - T+3 = IDLE.
- Throughput: one access per 3 cycles; at most one ack per cycle; `ack0` and `ack1` are never high together.
- `gnt`/`ack` are decoded from registered `state`/`owner` (glitch-free relative to `clock`). Memory outputs are decoded from registered latches.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: tie goes to the requester ≠ `last_grant`. After reset, the first tie goes to requester 0; alternation is strict under continuous contention.
- Undefined: fixed priority, requester 0 always wins ties. `last_grant` is still maintained but ignored.

## Test plan
- Single write then read, requester 0:
  - Write: req0 = 1, we0 = 1, addr0 = 512, wdata0 = 0x00000001 at T → `mem_write` = 1 with `mem_select` = 512 at T+1; ack0 at T+2.
  - Read back: req0, we0 = 0, addr0 = 512 → rdata0 = 0x00000001 with ack0 two cycles after request.
- Simultaneous req0/req1 held continuously, with and without macro:
  - With `MEM_ARB_ROUND_ROBIN_EN`: ack order 0,1,0,1.
  - Without the macro: requester 1 is starved (ack0 every 3 cycles, ack1 never).
- Requester 1 write to addr 5 = 0xDEADBEEF while req0 idle → only `ack1` pulses; `rdata0` unchanged; later req0 read of addr 5 returns 0xDEADBEEF.
- Reset asserted during ACCESS of a write to addr 7 (previous value 0x0) → `mem_write` stays 0, no ack, FSM returns to IDLE, addr 7 still reads 0x0.
- addr/wdata changed by requester during ACCESS → memory sees the originally latched values; `ack` timing unchanged.
